// File: rtl/round_ctrl_if.sv
// Bus between the game-logic FSM / switch front end and the round
// sequencer.
//   master: drives start, time_v, guess_valid, guess and ack; observes
//           the round status.
//   slave : the sequencer; drives state, target, remaining, cmp_r,
//           end_f and done.
interface round_ctrl_if;
  logic       start;
  logic [4:0] time_v;
  logic       guess_valid;
  logic [7:0] guess;
  logic       ack;
  logic [1:0] state;
  logic [7:0] target;
  logic [4:0] remaining;
  logic       cmp_r;
  logic       end_f;
  logic       done;

  modport master (
    output start, time_v, guess_valid, guess, ack,
    input  state, target, remaining, cmp_r, end_f, done
  );

  modport slave (
    input  start, time_v, guess_valid, guess, ack,
    output state, target, remaining, cmp_r, end_f, done
  );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: per-round sequencer for the binary number game.
// It latches a target from a free-running LFSR, counts the round down in
// whole seconds, and judges a guess against the target or declares a
// timeout.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : round_ctrl_if.slave
//                inputs : start, time_v, guess_valid, guess, ack
//                outputs: state, target, remaining, cmp_r, end_f, done
// Every output is registered.
module round_ctrl #(
  parameter int         TICK_CYCLES = 50_000_000,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input logic         clk,
  input logic         rst_n,
  round_ctrl_if.slave bus
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, BAD = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    target_q, target_d;
  logic [4:0]    rem_q, rem_d;
  logic          cmp_q, cmp_d;
  logic          end_q, end_d;
  logic          done_q, done_d;
  logic          tick;

  // The prescaler wraps on the tick cycle, so a tick is one second of RUN.
  assign tick = (pre_q == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      pre_q    <= '0;
      target_q <= '0;
      rem_q    <= '0;
      cmp_q    <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      pre_q    <= pre_d;
      target_q <= target_d;
      rem_q    <= rem_d;
      cmp_q    <= cmp_d;
      end_q    <= end_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    // Taps x^8+x^6+x^5+x^4+1. The feedback enters bit 0. A nonzero seed
    // never reaches the all-zero lockup state.
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pre_d    = pre_q;
    target_d = target_q;
    rem_d    = rem_q;
    cmp_d    = cmp_q;
    end_d    = end_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // start takes priority over ack in DONE.
        if (bus.start) begin
          target_d = lfsr_q;
          rem_d    = (bus.time_v == 5'd0) ? 5'd1 : bus.time_v;
          pre_d    = '0;
          cmp_d    = 1'b0;
          end_d    = 1'b0;
          state_d  = RUN;
        end else if (state_q == DONE && bus.ack) begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        // A guess beats a coincident final tick. remaining freezes.
        if (bus.guess_valid) begin
          cmp_d   = (bus.guess == target_q);
          end_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (tick) begin
          if (rem_q > 5'd1) begin
            rem_d = rem_q - 5'd1;
          end else begin
            rem_d   = 5'd0;
            end_d   = 1'b1;
            cmp_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.target    = target_q;
  assign bus.remaining = rem_q;
  assign bus.cmp_r     = cmp_q;
  assign bus.end_f     = end_q;
  assign bus.done      = done_q;
endmodule
